// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: one requester port of the data-memory arbiter
// Signals: req/we/addr/wdata/wstrb from the requester (held until gnt is seen),
//   gnt/rvalid/rdata/err back from the arbiter.
// Modports: master = requester side, slave = arbiter side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;
    modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the core (c) and debug/loader (d) requesters
// Ports: clk; reset (synchronous, active-high); c, d: requester ports (dmem_port_arbiter_if.slave);
//   core_stall: core requesting but not granted; mem_en/mem_we/mem_widx/mem_wdata/mem_wstrb: memory
//   access of the granted port; mem_rdata: synchronous read data, valid the cycle after a read strobe.
// Build option: DMEM_ARB_CORE_PRIO_EN selects fixed core priority; undefined gives round-robin.
module dmem_port_arbiter #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int MEM_WORDS = 64,
    localparam int SW        = DATA_W / 8,
    localparam int IW        = $clog2(MEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   c,
    dmem_port_arbiter_if.slave   d,
    output logic                 core_stall,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [IW-1:0]        mem_widx,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [SW-1:0]        mem_wstrb,
    input  logic [DATA_W-1:0]    mem_rdata
);
    localparam logic [ADDR_W-3:0] LIMIT = (ADDR_W-2)'(MEM_WORDS);
    logic              pick_d, gnt_c, gnt_d, any_gnt, sel_we, oob;
    logic              rd_pend, rd_owner, rd_err, rv_c, rv_d;
    logic [ADDR_W-3:0] widx;
    logic [DATA_W-1:0] rdata;
`ifdef DMEM_ARB_CORE_PRIO_EN
    assign pick_d = d.req & ~c.req;
`else
    logic last_d;
    // On a collision the port that did not win last time goes first.
    assign pick_d = d.req & (~c.req | ~last_d);
`endif
    assign gnt_d   = ~reset & pick_d;
    assign gnt_c   = ~reset & c.req & ~pick_d;
    assign any_gnt = gnt_c | gnt_d;
    assign sel_we  = pick_d ? d.we : c.we;
    assign widx    = pick_d ? d.addr[ADDR_W-1:2] : c.addr[ADDR_W-1:2];
    // Out-of-range accesses are still granted so the requester never hangs; memory is not touched.
    assign oob       = widx >= LIMIT;
    assign mem_en    = any_gnt & ~oob;
    assign mem_we    = mem_en & sel_we;
    assign mem_widx  = any_gnt ? widx[IW-1:0] : '0;
    assign mem_wdata = any_gnt ? (pick_d ? d.wdata : c.wdata) : '0;
    assign mem_wstrb = any_gnt ? (pick_d ? d.wstrb : c.wstrb) : '0;
    assign core_stall = ~reset & c.req & ~gnt_c;
    // rvalid is masked during reset so a read granted just before reset never returns.
    assign rv_c     = ~reset & rd_pend & ~rd_owner;
    assign rv_d     = ~reset & rd_pend & rd_owner;
    assign rdata    = rd_err ? '0 : mem_rdata;
    assign c.gnt    = gnt_c;
    assign d.gnt    = gnt_d;
    assign c.rvalid = rv_c;
    assign d.rvalid = rv_d;
    assign c.rdata  = rv_c ? rdata : '0;
    assign d.rdata  = rv_d ? rdata : '0;
    assign c.err    = (gnt_c & sel_we & oob) | (rv_c & rd_err);
    assign d.err    = (gnt_d & sel_we & oob) | (rv_d & rd_err);
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_pend  <= any_gnt & ~sel_we;
            rd_owner <= gnt_d;
            rd_err   <= oob;
        end
    end
`ifndef DMEM_ARB_CORE_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_d <= 1'b0;
        else if (any_gnt)
            last_d <= gnt_d;
    end
`endif
endmodule
